// File: rtl/cfg_pkg.sv
// Shared types and constants for the serial configuration loader.
// Holds the FSM state encoding, frame geometry and power-on routing values.
package cfg_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } cfg_state_e;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
    localparam int         FRAME_BITS        = 32;
    localparam int         PAYLOAD_BITS      = 24;
    localparam logic [4:0] PAYLOAD_LAST      = 5'(PAYLOAD_BITS - 1);

    // Identity routing: each CLB selects its own slice out of reset.
    localparam logic [1:0] SEL1_RST = 2'd0;
    localparam logic [1:0] SEL2_RST = 2'd1;
    localparam logic [1:0] SEL3_RST = 2'd2;
    localparam logic [1:0] SEL4_RST = 2'd3;

endpackage

// File: rtl/cfg_frame_check.sv
// Combinational validity check of a received payload (B0, B1, CHK).
// A frame is good when the checksum matches, B1 reserved bits are clear and the selects form a permutation.
module cfg_frame_check (
    input  logic [7:0] b0,
    input  logic [7:0] b1,
    input  logic [7:0] chk,
    output logic       good
);

    logic [1:0] s1, s2, s3, s4;
    logic       distinct;

    assign s1 = b0[1:0];
    assign s2 = b0[3:2];
    assign s3 = b0[5:4];
    assign s4 = b0[7:6];

    // Four pairwise-distinct 2-bit values are necessarily a permutation of 0..3.
    assign distinct = (s1 != s2) && (s1 != s3) && (s1 != s4) &&
                      (s2 != s3) && (s2 != s4) && (s3 != s4);

    assign good = ((b0 ^ b1) == chk) && (b1[6:0] == 7'd0) && distinct;

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Serial configuration loader: hunts for a sync byte, shadows a 24-bit payload,
// then atomically applies it to the routing outputs only if the frame checks good.
module cfg_bitstream_loader
    import cfg_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_din,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_abort,
    output logic [1:0] sel1,
    output logic [1:0] sel2,
    output logic [1:0] sel3,
    output logic [1:0] sel4,
    output logic       c_external,
    output logic       cfg_loaded,
    output logic       cfg_done,
    output logic       cfg_err,
    output cfg_state_e dbg_state
);

    // Handshake: a bit is consumed on a rising edge where cfg_valid && cfg_ready.
    cfg_state_e  state_q,  state_d;
    logic [7:0]  win_q,    win_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [23:0] shadow_q, shadow_d;
    logic [7:0]  route_q,  route_d;
    logic        cext_q,   cext_d;
    logic        loaded_q, loaded_d;
    logic        done_q,   done_d;
    logic        err_q,    err_d;
    logic        ready_q,  ready_d;

    logic accept;
    logic good;

    cfg_frame_check u_check (
        .b0  (shadow_q[23:16]),
        .b1  (shadow_q[15:8]),
        .chk (shadow_q[7:0]),
        .good(good)
    );

    assign accept = cfg_valid && ready_q;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        route_d  = route_q;
        cext_d   = cext_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_HUNT, ST_PAYLOAD: begin
                if (cfg_abort) begin
                    state_d = ST_HUNT;
                    win_d   = 8'd0;
                    cnt_d   = 5'd0;
                end else if (accept) begin
                    if (state_q == ST_HUNT) begin
                        win_d = {win_q[6:0], cfg_din};
                        if (win_d == SYNC_WORD) begin
                            state_d = ST_PAYLOAD;
                            cnt_d   = 5'd0;
                        end
                    end else begin
                        shadow_d = {shadow_q[22:0], cfg_din};
                        cnt_d    = cnt_q + 5'd1;
                        if (cnt_q == PAYLOAD_LAST) begin
                            state_d = ST_CHECK;
                            cnt_d   = 5'd0;
                        end
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_HUNT;
                win_d   = 8'd0;
                cnt_d   = 5'd0;
                if (good) begin
                    route_d  = shadow_q[23:16];
                    cext_d   = shadow_q[15];
                    loaded_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HUNT;
                win_d   = 8'd0;
                cnt_d   = 5'd0;
            end
        endcase

        ready_d = (state_d != ST_CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HUNT;
            win_q    <= 8'd0;
            cnt_q    <= 5'd0;
            shadow_q <= 24'd0;
            route_q  <= {SEL4_RST, SEL3_RST, SEL2_RST, SEL1_RST};
            cext_q   <= 1'b0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            route_q  <= route_d;
            cext_q   <= cext_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign sel1       = route_q[1:0];
    assign sel2       = route_q[3:2];
    assign sel3       = route_q[5:4];
    assign sel4       = route_q[7:6];
    assign c_external = cext_q;
    assign cfg_loaded = loaded_q;
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Directed bench for cfg_bitstream_loader: hand-computed frames, expected routing
// values and pulse counts checked with immediate assertions.
module tb_cfg_bitstream_loader;
    import cfg_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_din = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cfg_abort = 1'b0;
    logic [1:0] sel1, sel2, sel3, sel4;
    logic       c_external;
    logic       cfg_loaded;
    logic       cfg_done;
    logic       cfg_err;
    cfg_state_e dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_ref, err_ref;

    cfg_bitstream_loader #(.SYNC_WORD(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_din   (cfg_din),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_abort (cfg_abort),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .sel4      (sel4),
        .c_external(c_external),
        .cfg_loaded(cfg_loaded),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- pulse monitor ----------------
    always @(negedge clk) begin
        if (cfg_done) done_cnt++;
        if (cfg_err)  err_cnt++;
        n_tests++;
        assert (!(cfg_done && cfg_err)) else begin
            n_fail++;
            $error("FAIL done_err_exclusive: observed done=%0b err=%0b required not both", cfg_done, cfg_err);
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [1:0] e1, input logic [1:0] e2,
                               input logic [1:0] e3, input logic [1:0] e4,
                               input logic ece, input logic eload);
        chk({tag, "_sel"}, {24'd0, sel4, sel3, sel2, sel1}, {24'd0, e4, e3, e2, e1});
        chk({tag, "_cext"}, {31'd0, c_external}, {31'd0, ece});
        chk({tag, "_loaded"}, {31'd0, cfg_loaded}, {31'd0, eload});
    endtask

    // ---------------- drivers ----------------
    task automatic send_bit(input logic b);
        cfg_din   = b;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(b0);
        send_byte(b1);
        send_byte(c);
    endtask

    // Called #1 after the edge that accepted the last CHK bit (DUT is in CHECK).
    task automatic check_frame(input string tag, input logic good, input logic abort_in_check,
                               input logic [1:0] e1, input logic [1:0] e2,
                               input logic [1:0] e3, input logic [1:0] e4,
                               input logic ece, input logic eload);
        chk({tag, "_ready_low"}, {31'd0, cfg_ready}, 32'd0);
        chk({tag, "_no_early_done"}, {31'd0, cfg_done}, 32'd0);
        if (abort_in_check) begin
            cfg_abort = 1'b1;
            cfg_valid = 1'b1;
            cfg_din   = 1'b1;
        end
        @(posedge clk);
        #1;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        chk({tag, "_done"}, {31'd0, cfg_done}, {31'd0, good});
        chk({tag, "_err"}, {31'd0, cfg_err}, {31'd0, ~good});
        chk({tag, "_ready_back"}, {31'd0, cfg_ready}, 32'd1);
        chk_outputs(tag, e1, e2, e3, e4, ece, eload);
        @(posedge clk);
        #1;
        chk({tag, "_done_end"}, {31'd0, cfg_done}, 32'd0);
        chk({tag, "_err_end"}, {31'd0, cfg_err}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("in_reset", 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs("reset", 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
        chk("reset_done", {31'd0, cfg_done}, 32'd0);
        chk("reset_err", {31'd0, cfg_err}, 32'd0);
        chk("reset_ready", {31'd0, cfg_ready}, 32'd1);

        // Basic good frame.
        send_frame(8'h1B, 8'h80, 8'h9B);
        check_frame("good_1b", 1'b1, 1'b0, 2'd3, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1);

        // Garbage prefix before sync.
        err_ref = err_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_frame(8'h1B, 8'h80, 8'h9B);
        check_frame("prefix", 1'b1, 1'b0, 2'd3, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1);
        chk("prefix_no_err", err_cnt, err_ref);

        // Identity frame so later rejected frames would visibly change outputs.
        send_frame(8'hE4, 8'h00, 8'hE4);
        check_frame("good_e4", 1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1);

        // Bad checksum.
        send_frame(8'h1B, 8'h80, 8'h9A);
        check_frame("bad_chk", 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1);

        // Checksum fine but not a permutation.
        send_frame(8'h00, 8'h00, 8'h00);
        check_frame("not_perm", 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1);

        // Reserved B1 bit set (checksum consistent).
        send_frame(8'h1B, 8'h81, 8'h9A);
        check_frame("rsvd_bit", 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1);

        // Abort during CHECK is ignored; frame still applies.
        send_frame(8'h1B, 8'h80, 8'h9B);
        check_frame("abort_in_check", 1'b1, 1'b1, 2'd3, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1);

        // Abort after 10 payload bits (with a bit presented), then a full good frame.
        done_ref = done_cnt;
        err_ref  = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h1B);
        send_bit(1'b1); send_bit(1'b0);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_din   = 1'b1;
        @(posedge clk);
        #1;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        chk_outputs("after_abort", 2'd3, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1);
        chk("after_abort_ready", {31'd0, cfg_ready}, 32'd1);
        send_frame(8'hE4, 8'h00, 8'hE4);
        check_frame("abort_then_e4", 1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1);
        chk("abort_done_pulses", done_cnt - done_ref, 32'd1);
        chk("abort_err_pulses", err_cnt - err_ref, 32'd0);

        // Load a non-reset configuration, then reset mid-payload.
        send_frame(8'h1B, 8'h80, 8'h9B);
        check_frame("pre_reset", 1'b1, 1'b0, 2'd3, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1);
        done_ref = done_cnt;
        err_ref  = err_cnt;
        send_byte(8'hA5);
        send_byte(8'hE4);
        send_bit(1'b0); send_bit(1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs("mid_reset", 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs("post_reset", 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
        chk("post_reset_ready", {31'd0, cfg_ready}, 32'd1);
        send_frame(8'h1B, 8'h80, 8'h9B);
        check_frame("reset_then_1b", 1'b1, 1'b0, 2'd3, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1);
        chk("reset_done_pulses", done_cnt - done_ref, 32'd1);
        chk("reset_err_pulses", err_cnt - err_ref, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_bitstream_loader.md
CFG_BITSTREAM_LOADER -- requirements
Module: cfg_bitstream_loader

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hA5, meaning frame sync pattern.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cfg_din  input  1  serial config bit, MSB-first.
REQ-005 SHALL have port cfg_valid  input  1  cfg_din qualifier.
REQ-006 SHALL have port cfg_ready  output  1  loader accepts a bit when cfg_valid and cfg_ready are both high.
REQ-007 SHALL have port cfg_abort  input  1  synchronous abort of the frame in progress.
REQ-008 SHALL have ports sel1, sel2, sel3, sel4  output  2 each  slice-select per CLB, driven to the fabric router.
REQ-009 SHALL have port c_external  output  1  external carry-in to the fabric.
REQ-010 SHALL have port cfg_loaded  output  1  level: at least one good frame applied since reset.
REQ-011 SHALL have port cfg_done  output  1  one-cycle pulse: good frame applied.
REQ-012 SHALL have port cfg_err  output  1  one-cycle pulse: frame rejected.

Function
REQ-013 SHALL use a 32-bit frame: SYNC_WORD, B0={sel4,sel3,sel2,sel1}, B1={c_external,7'b0}, CHK=B0^B1; each byte MSB-first.
REQ-014 SHALL use states HUNT, PAYLOAD, CHECK.
REQ-015 HUNT SHALL shift accepted bits into an 8-bit window and go to PAYLOAD on the edge where the window equals SYNC_WORD; matching SHALL slide, so garbage prefix bits are tolerated.
REQ-016 PAYLOAD SHALL count 24 accepted bits (5-bit counter, 0..23) into a shadow register and go to CHECK on the edge accepting bit 23.
REQ-017 CHECK SHALL last exactly one cycle, hold cfg_ready low, then return to HUNT with the window and counter cleared.
REQ-018 A frame SHALL be good iff CHK matches, the B1 reserved bits are zero, and {sel1..sel4} is a permutation of {0,1,2,3}.
REQ-019 For a good frame, sel1..sel4, c_external, cfg_loaded=1 and cfg_done SHALL all update on the edge leaving CHECK, which is one cycle after the final CHK bit is accepted.
REQ-020 For a bad frame, cfg_err SHALL pulse on that same edge; the outputs of REQ-008, REQ-009 and REQ-010 SHALL stay unchanged.
REQ-021 Outputs SHALL never show a partially loaded configuration; only shadow registers change during PAYLOAD.
REQ-022 cfg_ready SHALL be high in HUNT and PAYLOAD; bits presented while cfg_ready is low are ignored.
REQ-023 cfg_abort SHALL take priority over bit acceptance: next state HUNT, window and counter cleared, no pulse, outputs unchanged.
REQ-024 cfg_abort during CHECK SHALL be ignored; the check completes.
REQ-025 cfg_done and cfg_err SHALL never be high in the same cycle.

Reset
REQ-026 On rst_n low: state=HUNT, window=0, counter=0, sel1=2'd0, sel2=2'd1, sel3=2'd2, sel4=2'd3, c_external=0, cfg_loaded=0, cfg_done=0, cfg_err=0; cfg_ready SHALL be 1 after release.
REQ-027 Reset asserted mid-frame SHALL discard the frame entirely; after release, loading restarts from HUNT.

Structure
REQ-028 Package cfg_pkg SHALL hold the state enum, the SYNC_WORD default, the frame/payload length constants (32/24) and the reset sel values.
REQ-029 The REQ-018 validity logic SHALL be a combinational sub-module, cfg_frame_check (inputs B0, B1, CHK; output good).

Verification
REQ-030 Reset, then frame A5 1B 80 9B -> one cycle after the last bit: sel1=3, sel2=2, sel3=1, sel4=0, c_external=1, cfg_done one pulse, cfg_loaded=1.
REQ-031 Prefix bits 1,0,1 followed by frame A5 1B 80 9B -> same result as REQ-030, no cfg_err.
REQ-032 Frame A5 1B 80 9A -> cfg_err pulse; outputs keep their prior values.
REQ-033 Frame A5 00 00 00 (not a permutation) -> cfg_err pulse; outputs unchanged.
REQ-034 cfg_abort after 10 payload bits, then a full good frame A5 E4 00 E4 -> sel1=0, sel2=1, sel3=2, sel4=3, c_external=0, single cfg_done pulse.
REQ-035 rst_n low for one cycle mid-payload, then a good frame -> reset values are seen first, then the new values, with no spurious pulse.
